// File: rtl/fft_loop_sequencer.sv
// fft_loop_sequencer: walks radix-2 FFT outer loops and drives CGRA IO pins.
// Optional FFT_SEQ_STALL_EN adds a stall input that freezes the dwell count.
module fft_loop_sequencer #(
    parameter int DATA_W    = 32,
    parameter int LOG2N_MAX = 10,
    parameter int II_W      = 4
) (
    input  logic              CGRA_Clock,
    input  logic              CGRA_Reset_n,
    input  logic              start,
    input  logic              abort,
    input  logic [3:0]        log2n,
    input  logic [II_W-1:0]   ii,
`ifdef FFT_SEQ_STALL_EN
    input  logic              stall,
`endif
    output logic [DATA_W-1:0] i_val,
    output logic [DATA_W-1:0] basedist_val,
    output logic [3:0]        stage,
    output logic              iter_valid,
    output logic              cgra_enable,
    output logic              busy,
    output logic              done,
    output logic              err
);

    localparam int AW    = LOG2N_MAX;
    localparam int CNT_W = LOG2N_MAX - 1 + II_W;

    typedef enum logic [1:0] {
        IDLE,
        ITER,
        DWELL,
        FIN
    } state_t;

    state_t           state_q, state_d;
    logic [AW-1:0]    i_q, i_d;
    logic [AW-1:0]    bd_q, bd_d;
    logic [AW-1:0]    n_half_q, n_half_d;
    logic [II_W-1:0]  ii_q, ii_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [3:0]       stage_q, stage_d;
    logic             iter_valid_q, iter_valid_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             err_q, err_d;

    logic             stall_w;
    logic             legal;
    logic [AW:0]      i_next;
    logic             wrap;
    logic [CNT_W-1:0] dwell_load;

`ifdef FFT_SEQ_STALL_EN
    assign stall_w = stall;
`else
    assign stall_w = 1'b0;
`endif

    assign legal      = (log2n != 4'd0) && (int'(log2n) <= LOG2N_MAX);
    assign i_next     = {1'b0, i_q} + {bd_q, 1'b0};
    assign wrap       = i_next >= {n_half_q, 1'b0};
    // bd <= N/2 and ii < 2^II_W, so the product always fits CNT_W bits
    assign dwell_load = CNT_W'(bd_q) * CNT_W'(ii_q);

    always_comb begin
        state_d      = state_q;
        i_d          = i_q;
        bd_d         = bd_q;
        n_half_d     = n_half_q;
        ii_d         = ii_q;
        cnt_d        = cnt_q;
        stage_d      = stage_q;
        iter_valid_d = 1'b0;
        busy_d       = busy_q;
        done_d       = 1'b0;
        err_d        = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (start && !abort) begin
                    if (legal) begin
                        n_half_d     = {{(AW-1){1'b0}}, 1'b1} << (log2n - 4'd1);
                        ii_d         = (ii == '0) ? II_W'(1) : ii;
                        i_d          = '0;
                        bd_d         = AW'(1);
                        stage_d      = 4'd0;
                        iter_valid_d = 1'b1;
                        busy_d       = 1'b1;
                        state_d      = ITER;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            ITER: begin
                cnt_d   = dwell_load;
                state_d = DWELL;
            end
            DWELL: begin
                if (!stall_w) begin
                    if (cnt_q == CNT_W'(1)) begin
                        if (!wrap) begin
                            i_d          = i_next[AW-1:0];
                            iter_valid_d = 1'b1;
                            state_d      = ITER;
                        end else if (bd_q == n_half_q) begin
                            busy_d  = 1'b0;
                            done_d  = 1'b1;
                            state_d = FIN;
                        end else begin
                            i_d          = '0;
                            bd_d         = bd_q << 1;
                            stage_d      = stage_q + 4'd1;
                            iter_valid_d = 1'b1;
                            state_d      = ITER;
                        end
                    end else begin
                        cnt_d = cnt_q - CNT_W'(1);
                    end
                end
            end
            FIN: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // abort wins over stall and over any pending advance
        if (abort && busy_q) begin
            state_d      = IDLE;
            i_d          = '0;
            bd_d         = '0;
            stage_d      = 4'd0;
            cnt_d        = '0;
            iter_valid_d = 1'b0;
            busy_d       = 1'b0;
            done_d       = 1'b0;
        end
    end

    always_ff @(posedge CGRA_Clock or negedge CGRA_Reset_n) begin
        if (!CGRA_Reset_n) begin
            state_q      <= IDLE;
            i_q          <= '0;
            bd_q         <= '0;
            n_half_q     <= '0;
            ii_q         <= '0;
            cnt_q        <= '0;
            stage_q      <= 4'd0;
            iter_valid_q <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            err_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            i_q          <= i_d;
            bd_q         <= bd_d;
            n_half_q     <= n_half_d;
            ii_q         <= ii_d;
            cnt_q        <= cnt_d;
            stage_q      <= stage_d;
            iter_valid_q <= iter_valid_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
            err_q        <= err_d;
        end
    end

    assign i_val        = DATA_W'(i_q);
    assign basedist_val = DATA_W'(bd_q);
    assign stage        = stage_q;
    assign iter_valid   = iter_valid_q;
    assign cgra_enable  = busy_q;
    assign busy         = busy_q;
    assign done         = done_q;
    assign err          = err_q;

endmodule

// File: tb/tb_fft_loop_sequencer.sv
// tb_fft_loop_sequencer: directed checks of the FFT outer-loop sequencer.
// Define FFT_SEQ_STALL_EN to include the stall scenario.
module tb_fft_loop_sequencer;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic        abort = 1'b0;
    logic [3:0]  log2n = 4'd0;
    logic [3:0]  ii = 4'd0;
`ifdef FFT_SEQ_STALL_EN
    logic        stall = 1'b0;
`endif
    logic [31:0] i_val;
    logic [31:0] basedist_val;
    logic [3:0]  stage;
    logic        iter_valid;
    logic        cgra_enable;
    logic        busy;
    logic        done;
    logic        err;

    int n_cmp = 0;
    int n_mis = 0;

    int npulse, busy_cnt, done_cnt, done_k, err_cnt, err_k, en_mis;
    int stall_lo = 0;
    int stall_hi = -1;
    int          pk [32];
    logic [31:0] pi [32];
    logic [31:0] pb [32];
    logic [3:0]  ps [32];

    int exp_k [15] = '{1, 5, 9, 13, 17, 21, 25, 29, 33, 40, 47, 54, 61, 74, 87};
    int exp_i [15] = '{0, 2, 4, 6, 8, 10, 12, 14, 0, 4, 8, 12, 0, 8, 0};
    int exp_b [15] = '{1, 1, 1, 1, 1, 1, 1, 1, 2, 2, 2, 2, 4, 4, 8};
    int exp_s [15] = '{0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 1, 1, 2, 2, 3};

    fft_loop_sequencer #(
        .DATA_W   (32),
        .LOG2N_MAX(10),
        .II_W     (4)
    ) dut (
        .CGRA_Clock  (clk),
        .CGRA_Reset_n(rst_n),
        .start       (start),
        .abort       (abort),
        .log2n       (log2n),
        .ii          (ii),
`ifdef FFT_SEQ_STALL_EN
        .stall       (stall),
`endif
        .i_val       (i_val),
        .basedist_val(basedist_val),
        .stage       (stage),
        .iter_valid  (iter_valid),
        .cgra_enable (cgra_enable),
        .busy        (busy),
        .done        (done),
        .err         (err)
    );

    always #5 clk = ~clk;

    task automatic launch(input logic [3:0] l, input logic [3:0] c);
        log2n = l;
        ii    = c;
        start = 1'b1;
    endtask

    // k counts edges after the start edge; sampling on the falling edge
    task automatic capture(input int maxk, input int start_k, input int abort_k);
        npulse = 0; busy_cnt = 0; done_cnt = 0; done_k = 0;
        err_cnt = 0; err_k = 0; en_mis = 0;
        for (int k = 1; k <= maxk; k++) begin
            @(negedge clk);
            if (iter_valid === 1'b1 && npulse < 32) begin
                pk[npulse] = k;
                pi[npulse] = i_val;
                pb[npulse] = basedist_val;
                ps[npulse] = stage;
                npulse++;
            end
            if (busy === 1'b1) busy_cnt++;
            if (cgra_enable !== busy) en_mis++;
            if (done === 1'b1) begin
                if (done_k == 0) done_k = k;
                done_cnt++;
            end
            if (err === 1'b1) begin
                if (err_k == 0) err_k = k;
                err_cnt++;
            end
            start = (k == start_k);
            abort = (k == abort_k);
            if (k == 1) begin
                log2n = 4'd7;
                ii    = 4'd9;
            end
`ifdef FFT_SEQ_STALL_EN
            stall = (k >= stall_lo && k <= stall_hi);
`endif
        end
        start = 1'b0;
        abort = 1'b0;
`ifdef FFT_SEQ_STALL_EN
        stall = 1'b0;
`endif
    endtask

    task automatic test_reset;
        repeat (2) @(negedge clk);
        n_cmp++;
        if ({i_val, basedist_val, stage, iter_valid, cgra_enable, busy, done, err} !== '0) begin
            n_mis++;
            $display("FAIL reset_outputs: got i=%0h bd=%0h st=%0h v=%b en=%b b=%b d=%b e=%b want all 0",
                     i_val, basedist_val, stage, iter_valid, cgra_enable, busy, done, err);
        end
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_full_run;
        launch(4'd4, 4'd3);
        capture(130, 0, 0);
        n_cmp++;
        if (npulse !== 15) begin
            n_mis++;
            $display("FAIL t1_pulses: got %0d want 15", npulse);
        end
        for (int j = 0; j < 15; j++) begin
            n_cmp++;
            if (pk[j] !== exp_k[j]) begin
                n_mis++;
                $display("FAIL t1_time[%0d]: got %0d want %0d", j, pk[j], exp_k[j]);
            end
            n_cmp++;
            if (pi[j] !== 32'(exp_i[j]) || pb[j] !== 32'(exp_b[j])) begin
                n_mis++;
                $display("FAIL t1_ibd[%0d]: got (%0d,%0d) want (%0d,%0d)",
                         j, pi[j], pb[j], exp_i[j], exp_b[j]);
            end
            n_cmp++;
            if (ps[j] !== 4'(exp_s[j])) begin
                n_mis++;
                $display("FAIL t1_stage[%0d]: got %0d want %0d", j, ps[j], exp_s[j]);
            end
        end
        n_cmp++;
        if (busy_cnt !== 111) begin
            n_mis++;
            $display("FAIL t1_busy: got %0d want 111", busy_cnt);
        end
        n_cmp++;
        if (done_k !== 112 || done_cnt !== 1) begin
            n_mis++;
            $display("FAIL t1_done: got k=%0d n=%0d want k=112 n=1", done_k, done_cnt);
        end
        n_cmp++;
        if (en_mis !== 0 || err_cnt !== 0) begin
            n_mis++;
            $display("FAIL t1_enable_err: got en_mis=%0d err=%0d want 0 0", en_mis, err_cnt);
        end
        n_cmp++;
        if (i_val !== 32'd0 || basedist_val !== 32'd8 || stage !== 4'd3) begin
            n_mis++;
            $display("FAIL t1_hold_last: got (%0d,%0d,%0d) want (0,8,3)",
                     i_val, basedist_val, stage);
        end
    endtask

    task automatic test_illegal;
        logic [3:0] bad [3];
        bad = '{4'd0, 4'd11, 4'd15};
        for (int j = 0; j < 3; j++) begin
            launch(bad[j], 4'd3);
            capture(6, 0, 0);
            n_cmp++;
            if (err_k !== 1 || err_cnt !== 1) begin
                n_mis++;
                $display("FAIL t2_err[%0d]: got k=%0d n=%0d want k=1 n=1", bad[j], err_k, err_cnt);
            end
            n_cmp++;
            if (busy_cnt !== 0 || npulse !== 0 || done_cnt !== 0) begin
                n_mis++;
                $display("FAIL t2_idle[%0d]: got busy=%0d pulses=%0d done=%0d want 0 0 0",
                         bad[j], busy_cnt, npulse, done_cnt);
            end
        end
    endtask

    task automatic test_single;
        launch(4'd1, 4'd0);
        capture(8, 0, 0);
        n_cmp++;
        if (npulse !== 1 || pk[0] !== 1) begin
            n_mis++;
            $display("FAIL t3_pulse: got n=%0d k=%0d want n=1 k=1", npulse, pk[0]);
        end
        n_cmp++;
        if (pi[0] !== 32'd0 || pb[0] !== 32'd1) begin
            n_mis++;
            $display("FAIL t3_ibd: got (%0d,%0d) want (0,1)", pi[0], pb[0]);
        end
        n_cmp++;
        if (busy_cnt !== 2 || done_k !== 3) begin
            n_mis++;
            $display("FAIL t3_timing: got busy=%0d done_k=%0d want 2 3", busy_cnt, done_k);
        end
    endtask

    task automatic test_ignore_start;
        launch(4'd4, 4'd3);
        capture(130, 20, 0);
        n_cmp++;
        if (npulse !== 15) begin
            n_mis++;
            $display("FAIL t4_pulses: got %0d want 15", npulse);
        end
        for (int j = 0; j < 15; j++) begin
            n_cmp++;
            if (pk[j] !== exp_k[j] || pi[j] !== 32'(exp_i[j]) || pb[j] !== 32'(exp_b[j])) begin
                n_mis++;
                $display("FAIL t4_seq[%0d]: got k=%0d (%0d,%0d) want k=%0d (%0d,%0d)",
                         j, pk[j], pi[j], pb[j], exp_k[j], exp_i[j], exp_b[j]);
            end
        end
        n_cmp++;
        if (done_k !== 112 || done_cnt !== 1 || busy_cnt !== 111) begin
            n_mis++;
            $display("FAIL t4_done: got k=%0d n=%0d busy=%0d want 112 1 111",
                     done_k, done_cnt, busy_cnt);
        end
    endtask

    task automatic test_abort;
        launch(4'd4, 4'd3);
        capture(70, 0, 50);
        n_cmp++;
        if (busy_cnt !== 50 || done_cnt !== 0) begin
            n_mis++;
            $display("FAIL t4_abort_busy: got busy=%0d done=%0d want 50 0", busy_cnt, done_cnt);
        end
        n_cmp++;
        if (npulse !== 11) begin
            n_mis++;
            $display("FAIL t4_abort_pulses: got %0d want 11", npulse);
        end
        n_cmp++;
        if (i_val !== 32'd0 || basedist_val !== 32'd0 || busy !== 1'b0 || cgra_enable !== 1'b0) begin
            n_mis++;
            $display("FAIL t4_abort_clear: got i=%0d bd=%0d busy=%b en=%b want 0 0 0 0",
                     i_val, basedist_val, busy, cgra_enable);
        end
    endtask

    task automatic test_async_reset;
        launch(4'd4, 4'd3);
        capture(10, 0, 0);
        #2 rst_n = 1'b0;
        #1;
        n_cmp++;
        if ({i_val, basedist_val, stage, iter_valid, cgra_enable, busy, done, err} !== '0) begin
            n_mis++;
            $display("FAIL t5_async: got i=%0h bd=%0h st=%0h v=%b en=%b b=%b d=%b e=%b want all 0",
                     i_val, basedist_val, stage, iter_valid, cgra_enable, busy, done, err);
        end
        @(negedge clk);
        rst_n = 1'b1;
        capture(5, 0, 0);
        n_cmp++;
        if (done_cnt !== 0 || busy_cnt !== 0) begin
            n_mis++;
            $display("FAIL t5_silent: got done=%0d busy=%0d want 0 0", done_cnt, busy_cnt);
        end
        launch(4'd4, 4'd3);
        capture(130, 0, 0);
        n_cmp++;
        if (npulse !== 15) begin
            n_mis++;
            $display("FAIL t5_pulses: got %0d want 15", npulse);
        end
        for (int j = 0; j < 15; j++) begin
            n_cmp++;
            if (pk[j] !== exp_k[j] || pi[j] !== 32'(exp_i[j]) || pb[j] !== 32'(exp_b[j])) begin
                n_mis++;
                $display("FAIL t5_seq[%0d]: got k=%0d (%0d,%0d) want k=%0d (%0d,%0d)",
                         j, pk[j], pi[j], pb[j], exp_k[j], exp_i[j], exp_b[j]);
            end
        end
        n_cmp++;
        if (done_k !== 112 || busy_cnt !== 111) begin
            n_mis++;
            $display("FAIL t5_done: got k=%0d busy=%0d want 112 111", done_k, busy_cnt);
        end
    endtask

`ifdef FFT_SEQ_STALL_EN
    task automatic test_stall;
        stall_lo = 2;
        stall_hi = 6;
        launch(4'd4, 4'd3);
        capture(135, 0, 0);
        stall_lo = 0;
        stall_hi = -1;
        n_cmp++;
        if (npulse !== 15) begin
            n_mis++;
            $display("FAIL t6_pulses: got %0d want 15", npulse);
        end
        for (int j = 0; j < 15; j++) begin
            n_cmp++;
            if (pk[j] !== ((j == 0) ? 1 : exp_k[j] + 5) || pi[j] !== 32'(exp_i[j])) begin
                n_mis++;
                $display("FAIL t6_seq[%0d]: got k=%0d i=%0d want k=%0d i=%0d",
                         j, pk[j], pi[j], (j == 0) ? 1 : exp_k[j] + 5, exp_i[j]);
            end
        end
        n_cmp++;
        if (done_k !== 117 || busy_cnt !== 116) begin
            n_mis++;
            $display("FAIL t6_done: got k=%0d busy=%0d want 117 116", done_k, busy_cnt);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_full_run();
        test_illegal();
        test_single();
        test_ignore_start();
        test_abort();
        test_async_reset();
`ifdef FFT_SEQ_STALL_EN
        test_stall();
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
